// File: rtl/stream_mux_rr_if.sv
// Stream mux bundle: N_CH input streams in, one stream out.
// slave = the mux side, master = the side that drives the channels.
interface stream_mux_rr_if #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
);
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_last;
    logic [N_CH-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [SEL_W-1:0]      out_ch;

    modport slave (
        input  in_data, in_valid, in_last, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_last, out_ch
    );

    modport master (
        output in_data, in_valid, in_last, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// Registered N:1 stream mux, fixed-select or round-robin arbitration.
// Define STREAM_MUX_RR_PKT_LOCK_EN to hold the grant for a whole packet.
module stream_mux_rr #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux_rr_if.slave bus
);
    localparam int NP = 1 << SEL_W;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] lock_ch;

    logic [NP-1:0]       vld;
    logic [NP-1:0]       lst;
    logic [NP*WIDTH-1:0] dat;
    logic [N_CH-1:0]     rdy;
    logic                g_vld;
    logic [SEL_W-1:0]    g_ch;
    logic                g_last;
    logic [WIDTH-1:0]    g_data;
    logic                can_load;
    logic                xfer;
    logic [SEL_W-1:0]    nxt_ptr;

    function automatic logic [SEL_W-1:0] rr_idx(
        input logic [SEL_W-1:0] base,
        input int               k
    );
        int s;
        s = int'(base) + k;
        if (s >= N_CH) s = s - N_CH;
        return SEL_W'(s);
    endfunction

    // Pad channel vectors so any SEL_W index stays in range
    always_comb begin
        vld = '0;
        lst = '0;
        dat = '0;
        vld[N_CH-1:0] = bus.in_valid;
        lst[N_CH-1:0] = bus.in_last;
        dat[N_CH*WIDTH-1:0] = bus.in_data;
    end

    // Grant from the current state; lowest rotated index wins
    always_comb begin
        g_vld = 1'b0;
        g_ch  = '0;
        if (state == LOCKED) begin
            g_vld = 1'b1;
            g_ch  = lock_ch;
        end else if (!bus.mode) begin
            g_ch  = bus.sel;
            g_vld = (int'(bus.sel) < N_CH) && vld[bus.sel];
        end else begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                if (vld[rr_idx(ptr, k)]) begin
                    g_vld = 1'b1;
                    g_ch  = rr_idx(ptr, k);
                end
            end
        end
    end

    assign can_load = !bus.out_valid || bus.out_ready;

    // One-hot ready towards the granted channel only
    always_comb begin
        rdy = '0;
        for (int i = 0; i < N_CH; i++) begin
            rdy[i] = g_vld && can_load && !rst && (int'(g_ch) == i);
        end
    end

    assign bus.in_ready = rdy;
    assign xfer    = |(bus.in_valid & rdy);
    assign g_last  = lst[g_ch];
    assign g_data  = dat[int'(g_ch)*WIDTH +: WIDTH];
    assign nxt_ptr = (int'(g_ch) == N_CH - 1) ? '0 : g_ch + 1'b1;

    // Arbitration state: packet lock and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            lock_ch <= '0;
        end else begin
`ifdef STREAM_MUX_RR_PKT_LOCK_EN
            if (xfer) begin
                if (g_last) begin
                    state <= IDLE;
                    ptr   <= nxt_ptr;
                end else if (state == IDLE) begin
                    state   <= LOCKED;
                    lock_ch <= g_ch;
                end
            end
`else
            state   <= IDLE;
            lock_ch <= '0;
            if (xfer) ptr <= nxt_ptr;
`endif
        end
    end

    // Output beat register: load on transfer, clear when drained
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_ch    <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= g_data;
            bus.out_last  <= g_last;
            bus.out_ch    <= g_ch;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter N_CH, default 8, number of input channels (2..16).
REQ-002 Parameter WIDTH, default 8, data bits per channel (1..64).
REQ-003 Parameter SEL_W, default 3, select/channel-index width; SHALL satisfy 2**SEL_W >= N_CH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N_CH  per-channel beat valid.
REQ-008 in_last  input  N_CH  per-channel end-of-packet marker, qualified by in_valid.
REQ-009 in_ready  output  N_CH  per-channel accept; at most one bit high per cycle.
REQ-010 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-011 sel  input  SEL_W  channel index used when mode = 0.
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_valid  output  1  out_data/out_last/out_ch hold a beat.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 out_last  output  1  registered in_last of the accepted beat.
REQ-016 out_ch  output  SEL_W  index of the channel the output beat came from.

Function
REQ-017 Channel i transfers when in_valid[i] && in_ready[i]; output transfers when out_valid && out_ready.
REQ-018 Output register SHALL load when (!out_valid || out_ready) and a transfer occurs; latency 1 cycle from input transfer to out_valid.
REQ-019 in_ready[g] = (grant valid, channel g) && (!out_valid || out_ready); all other in_ready bits 0; in_ready SHALL NOT depend on in_valid.
REQ-020 out_valid clears on output transfer with no simultaneous load; holds with all outputs stable while out_valid && !out_ready.
REQ-021 FSM states IDLE and LOCKED; grant is combinational from the current state only.
REQ-022 IDLE, mode = 0: grant = sel if sel < N_CH and in_valid[sel]; otherwise no grant.
REQ-023 IDLE, mode = 1: grant = first channel with in_valid set, searching ptr, ptr+1, ... modulo N_CH; none if all in_valid are 0.
REQ-024 IDLE -> LOCKED on a transfer with in_last = 0; the locked channel is recorded.
REQ-025 LOCKED: grant = locked channel only, regardless of mode, sel or other in_valid; LOCKED -> IDLE on a locked-channel transfer with in_last = 1.
REQ-026 A single-beat packet (in_last = 1 in IDLE) SHALL stay in IDLE.
REQ-027 On every transfer with in_last = 1, ptr <= (g+1) mod N_CH, wrapping N_CH-1 -> 0.
REQ-028 mode and sel SHALL be sampled only in IDLE; changes during LOCKED take effect after the packet ends.
REQ-029 sel >= N_CH in fixed mode: no grant, all in_ready 0, no state change.

Reset
REQ-030 When rst = 1 at a clock edge: out_valid 0, out_data 0, out_last 0, out_ch 0, ptr 0, state IDLE.
REQ-031 During rst, in_ready SHALL be all 0.
REQ-032 Reset mid-packet SHALL discard lock and any held output beat; no beat is replayed.

Configuration
REQ-033 Macro STREAM_MUX_RR_PKT_LOCK_EN defined: packet locking per REQ-024..REQ-026 is compiled in.
REQ-034 Macro not defined: FSM stays in IDLE and every beat is arbitrated independently; in_last is forwarded to out_last only; ptr advances after every transfer.

Verification
REQ-035 mode = 0, sel = 5, in_valid = 8'hFF, in_data ch5 = 8'hA5, out_ready = 1 -> only in_ready[5] high; next cycle out_data = 8'hA5, out_ch = 5.
REQ-036 mode = 1, in_valid = 8'hFF, in_last all 1, out_ready = 1 -> out_ch sequence 0,1,...,7,0, one beat per cycle.
REQ-037 mode = 1, PKT_LOCK_EN: ch2 sends 3 beats (last on the 3rd) while ch3 valid -> out_ch = 2,2,2 then 3; without the macro -> 2,3,...
REQ-038 out_ready held 0 for 4 cycles with a beat held -> out_data/out_ch stable, all in_ready 0; out_ready = 1 -> beat consumed and the next loaded in the same cycle.
REQ-039 mode = 0, sel = 7, N_CH = 6 -> in_ready = 0 and out_valid stays 0.
REQ-040 rst pulsed during LOCKED with out_valid = 1 -> next cycle out_valid 0, out_ch 0, IDLE; round-robin restarts at ch0.
